arb_grant_lock: RTL and testbench

Registered grant-lock stage directly downstream of the combinational fixed-priority arbiter. Captures the arbiter's one-hot grant and holds it stable for the granted requester's whole transaction, even as lower-index requests appear. Releases on transaction completion, request withdrawal, or an optional hold timeout. Exports the locked one-hot grant and its binary index to the shared-resource mux.

---
 rtl/arb_grant_lock.sv | 123 ++++++++++++
 tb/tb_arb_grant_lock.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_grant_lock.sv
// arb_grant_lock: registered grant-lock stage behind a fixed-priority arbiter.
// Captures a one-hot arbiter grant and holds it for the owner's whole transaction.
// The lock is released by txn_done or by the owner dropping its request.
// A one-cycle RELEASE gap (lock_valid=0) always separates two owners.
// Optional: define ARB_GRANT_LOCK_TIMEOUT_EN to compile in the MAX_HOLD force-release
// counter and the timeout pulse. Without it, timeout is tied to 0.
module arb_grant_lock #(
    parameter int SIZE     = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SIZE-1:0]  requests,
    input  logic [SIZE-1:0]  grants,
    input  logic             grant_valid,
    input  logic             txn_done,
    output logic [SIZE-1:0]  lock_grant,
    output logic [IDX_W-1:0] lock_index,
    output logic             lock_valid,
    output logic             timeout,
    output logic             onehot_err
);

    typedef enum logic [1:0] {IDLE, LOCKED, RELEASE} state_t;

    state_t           state;
    logic             grant_onehot;
    logic [IDX_W-1:0] grant_idx;
    logic             owner_release;

    // Reject bad parameterisations at elaboration time.
    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("arb_grant_lock: MAX_HOLD must be at least 2");
    end
    if (IDX_W < 1 || (64'(1) << IDX_W) < 64'(SIZE)) begin : g_bad_idx_w
        $error("arb_grant_lock: IDX_W too narrow for SIZE");
    end

`ifdef ARB_GRANT_LOCK_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_cnt;
`else
    // No force-release path in this build.
    assign timeout = 1'b0;
`endif

    // Grant qualification: exactly one bit set, and its binary index.
    always_comb begin
        grant_onehot = (grants != '0) && ((grants & (grants - SIZE'(1))) == '0);
        grant_idx    = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (grants[i]) grant_idx = IDX_W'(i);
        end
    end

    // Owner is finished: explicit completion or its request has gone away.
    always_comb begin
        owner_release = txn_done || ((requests & lock_grant) == '0);
    end

    // Lock FSM with registered outputs.
    // RELEASE is itself the one-cycle gap: a valid grant seen during it is captured
    // on the edge that leaves RELEASE, so the next owner is visible one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lock_grant <= '0;
            lock_index <= '0;
            lock_valid <= 1'b0;
            onehot_err <= 1'b0;
`ifdef ARB_GRANT_LOCK_TIMEOUT_EN
            hold_cnt   <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
`ifdef ARB_GRANT_LOCK_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE, RELEASE: begin
                    state <= IDLE;
                    if (grant_valid) begin
                        if (grant_onehot) begin
                            state      <= LOCKED;
                            lock_grant <= grants;
                            lock_index <= grant_idx;
                            lock_valid <= 1'b1;
`ifdef ARB_GRANT_LOCK_TIMEOUT_EN
                            hold_cnt   <= '0;
`endif
                        end else begin
                            onehot_err <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (owner_release) begin
                        // Normal release wins over a coincident timeout.
                        state      <= RELEASE;
                        lock_grant <= '0;
                        lock_valid <= 1'b0;
`ifdef ARB_GRANT_LOCK_TIMEOUT_EN
                    end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                        state      <= RELEASE;
                        lock_grant <= '0;
                        lock_valid <= 1'b0;
                        timeout    <= 1'b1;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
`endif
                    end
                end
                default: begin
                    state      <= IDLE;
                    lock_grant <= '0;
                    lock_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_grant_lock.sv
// tb_arb_grant_lock: directed scenarios plus randomized traffic checked against
// a behavioural owner/hold-count model of the grant lock.
module tb_arb_grant_lock;

    localparam int SIZE     = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 16;
`ifdef ARB_GRANT_LOCK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [SIZE-1:0]  requests = '0;
    logic [SIZE-1:0]  grants = '0;
    logic             grant_valid = 1'b0;
    logic             txn_done = 1'b0;
    logic [SIZE-1:0]  lock_grant;
    logic [IDX_W-1:0] lock_index;
    logic             lock_valid;
    logic             timeout;
    logic             onehot_err;

    int total = 0;
    int bad   = 0;

    arb_grant_lock #(.SIZE(SIZE), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .requests(requests), .grants(grants),
        .grant_valid(grant_valid), .txn_done(txn_done), .lock_grant(lock_grant),
        .lock_index(lock_index), .lock_valid(lock_valid), .timeout(timeout),
        .onehot_err(onehot_err)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the resource, for how many cycles, and sticky flags.
    int         m_owner = -1;
    int         m_held  = 0;
    bit         m_to    = 1'b0;
    bit         m_err   = 1'b0;
    logic [2:0] m_idx   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_held  <= 0;
            m_to    <= 1'b0;
            m_err   <= 1'b0;
            m_idx   <= '0;
        end else begin
            m_to <= 1'b0;
            if (m_owner >= 0) begin
                if (txn_done || !requests[m_owner]) m_owner <= -1;
                else if (TMO_EN && m_held == MAX_HOLD) begin
                    m_owner <= -1;
                    m_to    <= 1'b1;
                end else m_held <= m_held + 1;
            end else if (grant_valid) begin
                if ($countones(grants) == 1) begin
                    m_owner <= $clog2(grants);
                    m_held  <= 1;
                    m_idx   <= 3'($clog2(grants));
                end else m_err <= 1'b1;
            end
        end
    end

    task automatic set_in(input logic [7:0] r, input logic [7:0] g, input logic gv, input logic d);
        requests = r; grants = g; grant_valid = gv; txn_done = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if ({lock_grant, lock_index, lock_valid, timeout, onehot_err} !== 14'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {lock_grant, lock_index, lock_valid, timeout, onehot_err});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (lock_valid !== 1'b0 || onehot_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got valid=%b err=%b want 0 0", lock_valid, onehot_err);
        end
    endtask

    task automatic test_basic();
        set_in(8'h04, 8'h04, 1'b1, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin grants = '0; grant_valid = 1'b0; end
            total++;
            if (lock_valid !== 1'b1 || lock_grant !== 8'h04 || lock_index !== 3'd2 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL basic_hold cyc=%0d got v=%b g=%h i=%0d t=%b want 1 04 2 0",
                         c, lock_valid, lock_grant, lock_index, timeout);
            end
            if (c == 5) txn_done = 1'b1;
        end
        @(negedge clk);
        total++;
        if (lock_valid !== 1'b0 || lock_grant !== 8'h00 || lock_index !== 3'd2 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL basic_release got v=%b g=%h i=%0d t=%b want 0 00 2 0",
                     lock_valid, lock_grant, lock_index, timeout);
        end
        set_in(8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_no_preempt();
        set_in(8'h20, 8'h20, 1'b1, 1'b0);
        @(negedge clk);
        total++;
        if (lock_valid !== 1'b1 || lock_grant !== 8'h20 || lock_index !== 3'd5) begin
            bad++;
            $display("FAIL preempt_capture got v=%b g=%h i=%0d want 1 20 5", lock_valid, lock_grant, lock_index);
        end
        set_in(8'h21, 8'h01, 1'b1, 1'b0);
        repeat (4) begin
            @(negedge clk);
            total++;
            if (lock_valid !== 1'b1 || lock_grant !== 8'h20) begin
                bad++;
                $display("FAIL preempt_hold got v=%b g=%h want 1 20", lock_valid, lock_grant);
            end
        end
        txn_done = 1'b1;
        @(negedge clk);
        txn_done = 1'b0;
        total++;
        if (lock_valid !== 1'b0 || lock_grant !== 8'h00) begin
            bad++;
            $display("FAIL preempt_gap got v=%b g=%h want 0 00", lock_valid, lock_grant);
        end
        @(negedge clk);
        total++;
        if (lock_valid !== 1'b1 || lock_grant !== 8'h01 || lock_index !== 3'd0) begin
            bad++;
            $display("FAIL preempt_next got v=%b g=%h i=%0d want 1 01 0", lock_valid, lock_grant, lock_index);
        end
        set_in(8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        txn_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_withdraw();
        set_in(8'h80, 8'h80, 1'b1, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin grants = '0; grant_valid = 1'b0; end
            total++;
            if (lock_valid !== 1'b1 || lock_index !== 3'd7) begin
                bad++;
                $display("FAIL withdraw_hold cyc=%0d got v=%b i=%0d want 1 7", c, lock_valid, lock_index);
            end
            if (c == 3) requests = 8'h00;
        end
        @(negedge clk);
        total++;
        if (lock_valid !== 1'b0 || timeout !== 1'b0 || lock_index !== 3'd7) begin
            bad++;
            $display("FAIL withdraw_release got v=%b t=%b i=%0d want 0 0 7", lock_valid, timeout, lock_index);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n = 0;
        bit early_to = 1'b0;
        set_in(8'h02, 8'h02, 1'b1, 1'b0);
        @(negedge clk);
        grants = '0; grant_valid = 1'b0;
        while (lock_valid === 1'b1 && n < 300) begin
            n++;
            if (timeout !== 1'b0) early_to = 1'b1;
            @(negedge clk);
        end
        total++;
        if (early_to) begin
            bad++;
            $display("FAIL timeout_while_locked got=1 want=0");
        end
`ifdef ARB_GRANT_LOCK_TIMEOUT_EN
        total++;
        if (n != MAX_HOLD || timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_hold got cycles=%0d t=%b want %0d 1", n, timeout, MAX_HOLD);
        end
        @(negedge clk);
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse_width got=%b want=0", timeout);
        end
`else
        total++;
        if (n != 300 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL no_timeout_hold got cycles=%0d t=%b want 300 0", n, timeout);
        end
        txn_done = 1'b1;
        @(negedge clk);
`endif
        set_in(8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_error_reset();
        set_in(8'h00, 8'h06, 1'b1, 1'b0);
        @(negedge clk);
        total++;
        if (lock_valid !== 1'b0 || onehot_err !== 1'b1) begin
            bad++;
            $display("FAIL err_multihot got v=%b e=%b want 0 1", lock_valid, onehot_err);
        end
        set_in(8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        set_in(8'h08, 8'h08, 1'b1, 1'b0);
        @(negedge clk);
        grant_valid = 1'b0; grants = '0;
        total++;
        if (lock_valid !== 1'b1 || lock_grant !== 8'h08 || lock_index !== 3'd3 || onehot_err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky_lock got v=%b g=%h i=%0d e=%b want 1 08 3 1",
                     lock_valid, lock_grant, lock_index, onehot_err);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({lock_grant, lock_index, lock_valid, timeout, onehot_err} !== 14'h0) begin
            bad++;
            $display("FAIL async_reset got=%h want=0", {lock_grant, lock_index, lock_valid, timeout, onehot_err});
        end
        @(negedge clk);
        set_in(8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (lock_valid !== 1'b0 || onehot_err !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got v=%b e=%b t=%b want 0 0 0", lock_valid, onehot_err, timeout);
        end
    endtask

    task automatic test_simultaneous();
        for (int v = 0; v < 2; v++) begin
            set_in(8'h10, 8'h10, 1'b1, 1'b0);
            @(negedge clk);
            grants = '0; grant_valid = 1'b0;
            for (int c = 1; c <= MAX_HOLD; c++) begin
                total++;
                if (lock_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL simul_hold v=%0d cyc=%0d got=%b want=1", v, c, lock_valid);
                end
                if (c == MAX_HOLD) begin
                    if (v == 0) txn_done = 1'b1;
                    else requests = 8'h00;
                end
                @(negedge clk);
            end
            total++;
            if (lock_valid !== 1'b0 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL simul_release v=%0d got v=%b t=%b want 0 0", v, lock_valid, timeout);
            end
            set_in(8'h00, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [7:0]  eg;
        int          pw, pd, sel;
        for (int seg = 0; seg < 3; seg++) begin
            rst_n = 1'b0;
            set_in(8'h00, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            rst_n = 1'b1;
            pw  = (seg == 2) ? 63 : 7;
            pd  = (seg == 2) ? 63 : 11;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                eg = '0;
                if (m_owner >= 0) eg[m_owner] = 1'b1;
                total++;
                if (lock_grant !== eg || lock_valid !== (m_owner >= 0) || lock_index !== m_idx ||
                    timeout !== m_to || onehot_err !== m_err) begin
                    bad++;
                    $display("FAIL random seg=%0d i=%0d got g=%h v=%b i=%0d t=%b e=%b want g=%h v=%b i=%0d t=%b e=%b",
                             seg, i, lock_grant, lock_valid, lock_index, timeout, onehot_err,
                             eg, (m_owner >= 0), m_idx, m_to, m_err);
                end
                r = $urandom;
                requests = r[7:0];
                if (m_owner >= 0 && $urandom_range(0, pw) != 0) requests[m_owner] = 1'b1;
                sel = $urandom_range(0, 39);
                if (sel == 0) grants = 8'($urandom);
                else if (sel == 1) grants = '0;
                else begin
                    grants = '0;
                    grants[$urandom_range(0, 7)] = 1'b1;
                end
                grant_valid = ($urandom_range(0, 1) == 1);
                txn_done    = ($urandom_range(0, pd) == 0);
            end
        end
        set_in(8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before test end");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_no_preempt();
        test_withdraw();
        test_timeout();
        test_error_reset();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
